// File: rtl/memory_stage.sv
// Y86-64 memory stage: data-memory access, destination resolution and the
// W (writeback) pipeline register. m_valM/m_stat are combinational taps
// for the decode-stage bypass and PC-selection logic.
module memory_stage #(
   parameter int DMEM_BYTES = 1024   // power of two, at least 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  M_stat,
   input  logic [3:0]  M_icode,
   input  logic        M_Cnd,
   input  logic [63:0] M_valE,
   input  logic [63:0] M_valA,
   input  logic [63:0] M_valP,
   input  logic [3:0]  M_rA,
   input  logic [3:0]  M_rB,
   input  logic        W_stall,
   input  logic        W_bubble,
   input  logic        ld_en,
   input  logic [63:0] ld_addr,
   input  logic [7:0]  ld_data,
   output logic [63:0] m_valM,
   output logic [2:0]  m_stat,
   output logic [2:0]  W_stat,
   output logic [3:0]  W_icode,
   output logic [63:0] W_valE,
   output logic [63:0] W_valM,
   output logic [3:0]  W_dstE,
   output logic [3:0]  W_dstM
);

   localparam int AW = $clog2(DMEM_BYTES);

   localparam logic [2:0] STAT_BUB = 3'd0;
   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_ADR = 3'd3;

   localparam logic [3:0] I_NOP   = 4'h1;
   localparam logic [3:0] I_CMOV  = 4'h2;
   localparam logic [3:0] I_IRMOV = 4'h3;
   localparam logic [3:0] I_RMMOV = 4'h4;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] I_CALL  = 4'h8;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_PUSH  = 4'hA;
   localparam logic [3:0] I_POP   = 4'hB;

   localparam logic [3:0] R_RSP  = 4'h4;
   localparam logic [3:0] R_NONE = 4'hF;

   logic [7:0]    mem [DMEM_BYTES];

   logic [63:0]   mem_addr;
   logic [63:0]   wr_data;
   logic          mem_rd;
   logic          mem_wr;
   logic          addr_ok;
   logic          wr_fire;
   logic [AW-1:0] base_idx;
   logic [63:0]   rd_word;
   logic [3:0]    dst_e;
   logic [3:0]    dst_m;

   // Decode the access kind, its address and its write data from icode.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      mem_addr = M_valE;
      wr_data  = M_valA;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      case (M_icode)
         I_RMMOV, I_PUSH: mem_wr = 1'b1;
         I_CALL: begin
            mem_wr  = 1'b1;
            wr_data = M_valP;
         end
         I_MRMOV: mem_rd = 1'b1;
         I_POP, I_RET: begin
            mem_rd   = 1'b1;
            mem_addr = M_valA;
         end
         default: ;
      endcase
   end

   assign addr_ok  = (mem_addr <= 64'(DMEM_BYTES - 8));
   assign base_idx = mem_addr[AW-1:0];
   assign wr_fire  = mem_wr && addr_ok && (M_stat == STAT_AOK) && !reset;

   // Gather the 8 little-endian bytes at the access address.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < 8; i++)
         rd_word[8*i +: 8] = mem[base_idx + AW'(i)];
   end

   assign m_valM = (mem_rd && addr_ok) ? rd_word : 64'd0;
   assign m_stat = ((mem_rd || mem_wr) && !addr_ok) ? STAT_ADR : M_stat;

   // Resolve register destinations for writeback.
   always_comb begin
      dst_e = R_NONE;
      dst_m = R_NONE;
      case (M_icode)
         I_CMOV:                       dst_e = M_Cnd ? M_rB : R_NONE;
         I_IRMOV, I_OPQ:               dst_e = M_rB;
         I_PUSH, I_POP, I_CALL, I_RET: dst_e = R_RSP;
         default: ;
      endcase
      if (M_icode == I_MRMOV || M_icode == I_POP)
         dst_m = M_rA;
   end

   // Data memory writes: loader bytes first, pipeline word last so it wins collisions.
   // NOTE: the array has no reset; clearing a RAM costs a port per byte and the contents are loaded anyway.
   always_ff @(posedge clk) begin
      if (ld_en && (ld_addr < 64'(DMEM_BYTES)))
         mem[ld_addr[AW-1:0]] <= ld_data;
      if (wr_fire)
         for (int i = 0; i < 8; i++)
            mem[base_idx + AW'(i)] <= wr_data[8*i +: 8];
   end

   // W pipeline register: stall holds, bubble inserts a NOP, otherwise capture.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (reset) begin
         W_stat  <= STAT_BUB;
         W_icode <= I_NOP;
         W_valE  <= '0;
         W_valM  <= '0;
         W_dstE  <= R_NONE;
         W_dstM  <= R_NONE;
      end else if (W_stall) begin
         W_stat  <= W_stat;
      end else if (W_bubble) begin
         W_stat  <= STAT_BUB;
         W_icode <= I_NOP;
         W_valE  <= '0;
         W_valM  <= '0;
         W_dstE  <= R_NONE;
         W_dstM  <= R_NONE;
      end else begin
         W_stat  <= m_stat;
         W_icode <= M_icode;
         W_valE  <= M_valE;
         W_valM  <= m_valM;
         W_dstE  <= dst_e;
         W_dstM  <= dst_m;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: hand-computed vectors checked with
// immediate assertions, one linear stimulus sequence.
module tb_memory_stage;

   localparam int DMEM_BYTES = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  M_stat;
   logic [3:0]  M_icode;
   logic        M_Cnd;
   logic [63:0] M_valE, M_valA, M_valP;
   logic [3:0]  M_rA, M_rB;
   logic        W_stall, W_bubble;
   logic        ld_en;
   logic [63:0] ld_addr;
   logic [7:0]  ld_data;
   logic [63:0] m_valM;
   logic [2:0]  m_stat;
   logic [2:0]  W_stat;
   logic [3:0]  W_icode;
   logic [63:0] W_valE, W_valM;
   logic [3:0]  W_dstE, W_dstM;

   int n_assert = 0;
   int n_fail   = 0;

   memory_stage #(.DMEM_BYTES(DMEM_BYTES)) dut (
      .clk(clk), .reset(reset),
      .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
      .M_valE(M_valE), .M_valA(M_valA), .M_valP(M_valP),
      .M_rA(M_rA), .M_rB(M_rB),
      .W_stall(W_stall), .W_bubble(W_bubble),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .m_valM(m_valM), .m_stat(m_stat),
      .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
      .W_dstE(W_dstE), .W_dstM(W_dstM)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_assert++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input logic [2:0] stat, input logic [3:0] icode, input logic cnd,
                        input logic [63:0] vale, input logic [63:0] vala, input logic [63:0] valp,
                        input logic [3:0] ra, input logic [3:0] rb);
      M_stat = stat; M_icode = icode; M_Cnd = cnd;
      M_valE = vale; M_valA = vala; M_valP = valp;
      M_rA = ra; M_rB = rb;
      #1;
   endtask

   task automatic nop();
      set_m(3'd1, 4'h1, 1'b0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
   endtask

   // Pipeline rmmovq of a full word.
   task automatic store(input logic [63:0] addr, input logic [63:0] data);
      set_m(3'd1, 4'h4, 1'b0, addr, data, 64'd0, 4'hF, 4'hF);
      tick();
   endtask

   // Combinational mrmovq read; leaves the stage idle afterwards.
   task automatic load_check(input string tag, input logic [63:0] addr, input logic [63:0] expected);
      set_m(3'd1, 4'h5, 1'b0, addr, 64'd0, 64'd0, 4'h1, 4'hF);
      check(tag, m_valM, expected);
      nop();
   endtask

   task automatic check_bubble(input string tag);
      check({tag, ".W_stat"},  64'(W_stat),  64'd0);
      check({tag, ".W_icode"}, 64'(W_icode), 64'd1);
      check({tag, ".W_valE"},  W_valE,       64'd0);
      check({tag, ".W_valM"},  W_valM,       64'd0);
      check({tag, ".W_dstE"},  64'(W_dstE),  64'hF);
      check({tag, ".W_dstM"},  64'(W_dstM),  64'hF);
   endtask

   initial begin
      logic [63:0] pat;
      reset = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      nop();
      #11;
      check_bubble("reset");
      reset = 1'b0;

      // Loader writes 0x0807060504030201 at 0x10, one byte per cycle.
      pat = 64'h0807060504030201;
      for (int i = 0; i < 8; i++) begin
         ld_en = 1'b1; ld_addr = 64'h10 + 64'(i); ld_data = pat[8*i +: 8];
         tick();
      end
      ld_en = 1'b0;

      // mrmovq from 0x10 into rA=3.
      set_m(3'd1, 4'h5, 1'b0, 64'h10, 64'd0, 64'd0, 4'h3, 4'hF);
      check("mrmov.m_valM", m_valM, 64'h0807060504030201);
      check("mrmov.m_stat", 64'(m_stat), 64'd1);
      tick();
      check("mrmov.W_valM",  W_valM,       64'h0807060504030201);
      check("mrmov.W_dstM",  64'(W_dstM),  64'h3);
      check("mrmov.W_dstE",  64'(W_dstE),  64'hF);
      check("mrmov.W_icode", 64'(W_icode), 64'h5);
      check("mrmov.W_stat",  64'(W_stat),  64'd1);
      check("mrmov.W_valE",  W_valE,       64'h10);

      // rmmovq then read back.
      store(64'h20, 64'hDEADBEEF);
      load_check("rmmov.readback", 64'h20, 64'hDEADBEEF);

      // Write with non-AOK status is suppressed but status passes through.
      store(64'h30, 64'h0123456789ABCDEF);
      set_m(3'd2, 4'h4, 1'b0, 64'h30, 64'h1111, 64'd0, 4'hF, 4'hF);
      check("hlt.m_stat", 64'(m_stat), 64'd2);
      tick();
      check("hlt.W_stat", 64'(W_stat), 64'd2);
      load_check("hlt.no_write", 64'h30, 64'h0123456789ABCDEF);

      // Highest valid address and address 0, then a call that straddles the end.
      store(64'(DMEM_BYTES - 8), 64'hA1A2A3A4A5A6A7A8);
      load_check("edge.readback", 64'(DMEM_BYTES - 8), 64'hA1A2A3A4A5A6A7A8);
      store(64'h0, 64'h5555666677778888);
      set_m(3'd1, 4'h8, 1'b0, 64'(DMEM_BYTES - 4), 64'd0, 64'h40, 4'hF, 4'hF);
      check("call_adr.m_stat", 64'(m_stat), 64'd3);
      check("call_adr.m_valM", m_valM, 64'd0);
      tick();
      check("call_adr.W_stat", 64'(W_stat), 64'd3);
      check("call_adr.W_dstE", 64'(W_dstE), 64'h4);
      load_check("call_adr.top_unchanged", 64'(DMEM_BYTES - 8), 64'hA1A2A3A4A5A6A7A8);
      load_check("call_adr.low_unchanged", 64'h0, 64'h5555666677778888);

      // Read one byte past the last valid address.
      set_m(3'd1, 4'h5, 1'b0, 64'(DMEM_BYTES - 7), 64'd0, 64'd0, 4'h2, 4'hF);
      check("mrmov_adr.m_stat", 64'(m_stat), 64'd3);
      check("mrmov_adr.m_valM", m_valM, 64'd0);

      // Valid call writes valP; popq reads at valA.
      set_m(3'd1, 4'h8, 1'b0, 64'h80, 64'd0, 64'h40, 4'hF, 4'hF);
      tick();
      set_m(3'd1, 4'hB, 1'b0, 64'h88, 64'h80, 64'd0, 4'h6, 4'hF);
      check("pop.m_valM", m_valM, 64'h40);
      tick();
      check("pop.W_dstM", 64'(W_dstM), 64'h6);
      check("pop.W_dstE", 64'(W_dstE), 64'h4);
      check("pop.W_valE", W_valE, 64'h88);

      // Out-of-range loader byte is ignored.
      nop();
      ld_en = 1'b1; ld_addr = 64'(DMEM_BYTES); ld_data = 8'hAA;
      tick();
      ld_en = 1'b0;
      load_check("ld_oob.ignored", 64'h0, 64'h5555666677778888);

      // Same-cycle collision: pipeline byte wins over loader byte.
      ld_en = 1'b1; ld_addr = 64'h60; ld_data = 8'hFF;
      store(64'h60, 64'h1122334455667788);
      ld_en = 1'b0;
      load_check("collision.pipe_wins", 64'h60, 64'h1122334455667788);

      // cmovXX destination follows the condition.
      set_m(3'd1, 4'h2, 1'b0, 64'h7, 64'd0, 64'd0, 4'h1, 4'h5);
      tick();
      check("cmov_nc.W_dstE", 64'(W_dstE), 64'hF);
      set_m(3'd1, 4'h2, 1'b1, 64'h7, 64'd0, 64'd0, 4'h1, 4'h5);
      tick();
      check("cmov_c.W_dstE", 64'(W_dstE), 64'h5);

      // Stall has priority over bubble for two cycles.
      set_m(3'd1, 4'h3, 1'b0, 64'h99, 64'd0, 64'd0, 4'hF, 4'h9);
      W_stall = 1'b1; W_bubble = 1'b1;
      tick();
      tick();
      check("stall.W_icode", 64'(W_icode), 64'h2);
      check("stall.W_dstE",  64'(W_dstE),  64'h5);
      check("stall.W_valE",  W_valE,       64'h7);
      check("stall.W_stat",  64'(W_stat),  64'd1);
      W_stall = 1'b0;
      tick();
      check_bubble("bubble");
      W_bubble = 1'b0;

      // Reset asserted between edges during a pushq.
      store(64'h50, 64'hCAFEF00D12345678);
      set_m(3'd1, 4'h3, 1'b0, 64'h77, 64'd0, 64'd0, 4'hF, 4'h2);
      tick();
      check("pre_reset.W_dstE", 64'(W_dstE), 64'h2);
      set_m(3'd1, 4'hA, 1'b0, 64'h50, 64'hBAD, 64'd0, 4'hF, 4'h4);
      #1 reset = 1'b1;
      #1;
      check_bubble("async_reset");
      tick();
      reset = 1'b0;
      load_check("async_reset.no_write", 64'h50, 64'hCAFEF00D12345678);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
